parking_gate_arbiter: RTL and testbench

- Sequences the parking lot's entry and exit gates and arbitrates access to the shared occupancy counter.
- Takes car-waiting requests and car-passed pulses from the two gate sensor FSMs.
- Opens one gate at a time and issues exactly one inc or dec pulse per car that actually passes.
- Sits between the sensor FSMs and the occupancy counter, and consumes that counter's full/clear flags.

---
 rtl/parking_pkg.sv | 19 +
 rtl/gate_timer.sv | 35 +++
 rtl/parking_gate_arbiter.sv | 124 ++++++++++++
 tb/tb_parking_gate_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate arbiter.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY_OPEN,
        EXIT_OPEN,
        COMMIT_IN,
        COMMIT_OUT
    } gate_state_t;

    typedef enum logic {
        SIDE_ENTRY,
        SIDE_EXIT
    } side_t;

    localparam int DEFAULT_GATE_TIMEOUT = 50;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module gate_timer #(
    parameter int TW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          expired
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Opens one parking gate at a time, round-robins ties between entry and exit,
// and issues a single inc/dec pulse to the occupancy counter per car that passes.
//
// state      | meaning
// IDLE       | both gates closed, choosing the next eligible request
// ENTRY_OPEN | entry gate open, waiting for entry_passed or timeout
// EXIT_OPEN  | exit gate open, waiting for exit_passed or timeout
// COMMIT_IN  | inc pulse, gates closed
// COMMIT_OUT | dec pulse, gates closed
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int GATE_TIMEOUT = DEFAULT_GATE_TIMEOUT,
    localparam int TW = $clog2(GATE_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic entry_req,
    input  logic exit_req,
    input  logic entry_passed,
    input  logic exit_passed,
    input  logic full,
    input  logic clear,
    output logic entry_open,
    output logic exit_open,
    output logic inc,
    output logic dec,
    output logic lot_full_lamp,
    output logic timeout_flag
);

    gate_state_t state_q, state_d;
    side_t       last_served_q, last_served_d;
    logic        timeout_q, timeout_d;
    logic        timer_load;
    logic        timer_en;
    logic        timer_expired;
    logic        entry_elig;
    logic        exit_elig;

    assign entry_elig = entry_req && !full;
    assign exit_elig  = exit_req && !clear;

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        timeout_d     = 1'b0;
        timer_load    = 1'b0;
        case (state_q)
            IDLE: begin
                // last_served only moves on a contested grant
                if (entry_elig && exit_elig) begin
                    timer_load = 1'b1;
                    if (last_served_q == SIDE_EXIT) begin
                        state_d       = ENTRY_OPEN;
                        last_served_d = SIDE_ENTRY;
                    end else begin
                        state_d       = EXIT_OPEN;
                        last_served_d = SIDE_EXIT;
                    end
                end else if (entry_elig) begin
                    timer_load = 1'b1;
                    state_d    = ENTRY_OPEN;
                end else if (exit_elig) begin
                    timer_load = 1'b1;
                    state_d    = EXIT_OPEN;
                end
            end
            ENTRY_OPEN: begin
                if (entry_passed) begin
                    state_d = COMMIT_IN;
                end else if (timer_expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            EXIT_OPEN: begin
                if (exit_passed) begin
                    state_d = COMMIT_OUT;
                end else if (timer_expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            COMMIT_IN:  state_d = IDLE;
            COMMIT_OUT: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_served_q <= SIDE_EXIT;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            timeout_q     <= timeout_d;
        end
    end

    assign timer_en = (state_q == ENTRY_OPEN) || (state_q == EXIT_OPEN);

    // Loading GATE_TIMEOUT-1 keeps the gate open for exactly GATE_TIMEOUT cycles
    gate_timer #(
        .TW(TW)
    ) u_gate_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .load_val(TW'(GATE_TIMEOUT - 1)),
        .en      (timer_en),
        .expired (timer_expired)
    );

    assign entry_open    = (state_q == ENTRY_OPEN);
    assign exit_open     = (state_q == EXIT_OPEN);
    assign inc           = (state_q == COMMIT_IN);
    assign dec           = (state_q == COMMIT_OUT);
    assign lot_full_lamp = (state_q == IDLE) && entry_req && full;
    assign timeout_flag  = timeout_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter with a behavioural occupancy counter.
module tb_parking_gate_arbiter;

    localparam int GT  = 8;
    localparam int CAP = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic entry_req = 1'b0;
    logic exit_req = 1'b0;
    logic entry_passed = 1'b0;
    logic exit_passed = 1'b0;
    logic full;
    logic clear;
    logic entry_open;
    logic exit_open;
    logic inc;
    logic dec;
    logic lot_full_lamp;
    logic timeout_flag;

    int count = 0;
    int n_checks = 0;
    int n_errors = 0;
    int both_open_seen = 0;
    int both_pulse_seen = 0;
    int w;
    int n;

    assign full  = (count >= CAP);
    assign clear = (count == 0);

    parking_gate_arbiter #(
        .GATE_TIMEOUT(GT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .entry_req    (entry_req),
        .exit_req     (exit_req),
        .entry_passed (entry_passed),
        .exit_passed  (exit_passed),
        .full         (full),
        .clear        (clear),
        .entry_open   (entry_open),
        .exit_open    (exit_open),
        .inc          (inc),
        .dec          (dec),
        .lot_full_lamp(lot_full_lamp),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (inc) count <= count + 1;
        else if (dec) count <= count - 1;
    end

    always @(negedge clk) begin
        if (entry_open && exit_open) both_open_seen <= both_open_seen + 1;
        if (inc && dec) both_pulse_seen <= both_pulse_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // side 0 = entry, 1 = exit; waited = budget+1 if the gate never opened
    task automatic wait_open(input bit side, input int budget, output int waited);
        waited = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (side ? exit_open : entry_open) begin
                waited = i;
                return;
            end
        end
    endtask

    // pass_at = 0 means never pass; returns number of cycles the gate was open
    task automatic hold_open(input bit side, input int pass_at, output int ncyc);
        ncyc = 0;
        while ((side ? exit_open : entry_open) && ncyc < 40) begin
            ncyc++;
            entry_passed = !side && (ncyc == pass_at);
            exit_passed  = side && (ncyc == pass_at);
            tick();
        end
        entry_passed = 1'b0;
        exit_passed  = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_entry_open", entry_open, 0);
        check("rst_exit_open", exit_open, 0);
        check("rst_inc", inc, 0);
        check("rst_dec", dec, 0);
        check("rst_timeout", timeout_flag, 0);
        check("rst_lamp", lot_full_lamp, 0);

        // single entry, pass on third open cycle
        reset = 1'b1;
        entry_req = 1'b1;
        wait_open(0, 5, w);
        check("s1_grant_latency", w, 1);
        hold_open(0, 3, n);
        check("s1_open_cycles", n, 3);
        check("s1_commit_inc", inc, 1);
        check("s1_commit_entry_low", entry_open, 0);
        check("s1_commit_exit_low", exit_open, 0);
        check("s1_commit_dec", dec, 0);
        entry_req = 1'b0;
        tick();
        check("s1_inc_single", inc, 0);
        check("s1_count", count, 1);

        // round-robin: entry, exit, entry, exit
        entry_req = 1'b1;
        exit_req  = 1'b1;
        wait_open(0, 5, w);
        check("s2_entry_first", w, 1);
        check("s2_exit_closed", exit_open, 0);
        hold_open(0, 2, n);
        check("s2_inc1", inc, 1);
        wait_open(1, 5, w);
        check("s2_exit_second", w, 2);
        hold_open(1, 1, n);
        check("s2_dec1", dec, 1);
        wait_open(0, 5, w);
        check("s2_entry_third", w, 2);
        hold_open(0, 1, n);
        check("s2_inc2", inc, 1);
        wait_open(1, 5, w);
        check("s2_exit_fourth", w, 2);
        hold_open(1, 1, n);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        check("s2_dec2", dec, 1);
        tick();
        check("s2_count", count, 1);

        // fill to capacity, then free a slot
        entry_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_open(0, 5, w);
            hold_open(0, 1, n);
            check("s3_fill_inc", inc, 1);
        end
        wait_open(0, 10, w);
        check("s3_entry_blocked", w, 11);
        check("s3_count_full", count, 3);
        check("s3_lamp", lot_full_lamp, 1);
        exit_req = 1'b1;
        wait_open(1, 5, w);
        check("s3_exit_grant", w, 1);
        hold_open(1, 1, n);
        exit_req = 1'b0;
        check("s3_dec", dec, 1);
        wait_open(0, 5, w);
        check("s3_reopen_m3", w, 2);
        hold_open(0, 1, n);
        entry_req = 1'b0;
        check("s3_inc", inc, 1);
        tick();
        check("s3_count_refull", count, 3);

        // drain, then exit at count 0 must stay closed
        exit_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_open(1, 5, w);
            hold_open(1, 1, n);
            check("s4_drain_dec", dec, 1);
        end
        wait_open(1, 12, w);
        check("s4_exit_blocked", w, 13);
        check("s4_exit_low", exit_open, 0);
        check("s4_count_zero", count, 0);
        exit_req = 1'b0;

        // timeout, then pass on the final timer cycle
        entry_req = 1'b1;
        wait_open(0, 5, w);
        check("s5_grant", w, 1);
        hold_open(0, 0, n);
        check("s5_timeout_cycles", n, GT);
        check("s5_timeout_flag", timeout_flag, 1);
        check("s5_no_inc", inc, 0);
        wait_open(0, 5, w);
        check("s5_regrant", w, 1);
        check("s5_flag_single", timeout_flag, 0);
        hold_open(0, GT, n);
        check("s5_last_cycle_open", n, GT);
        check("s5_last_cycle_inc", inc, 1);
        check("s5_last_cycle_no_to", timeout_flag, 0);
        entry_req = 1'b0;
        tick();
        check("s5_count", count, 1);
        check("s5_flag_after_commit", timeout_flag, 0);

        // async reset while exit gate is open
        entry_req = 1'b1;
        exit_req  = 1'b1;
        wait_open(0, 5, w);
        check("s6_tie_entry", w, 1);
        hold_open(0, 1, n);
        entry_req = 1'b0;
        wait_open(1, 5, w);
        check("s6_exit_open", w, 2);
        tick();
        check("s6_exit_still_open", exit_open, 1);
        #2;
        reset = 1'b0;
        #1;
        check("s6_async_close", exit_open, 0);
        check("s6_no_dec", dec, 0);
        tick();
        tick();
        check("s6_count_kept", count, 2);
        reset = 1'b1;
        entry_req = 1'b1;
        wait_open(0, 5, w);
        check("s6_post_rst_entry", w, 1);
        check("s6_post_rst_exit_low", exit_open, 0);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        tick();

        check("inv_both_open", both_open_seen, 0);
        check("inv_both_pulse", both_pulse_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
